// File: rtl/vmul_pkg.sv
// rtl/vmul_pkg.sv - shared lane geometry, enums and lane mapping helper for the vector multiplier
package vmul_pkg;

    typedef enum logic [1:0] {
        P8     = 2'b00,
        P16    = 2'b01,
        P32    = 2'b10,
        P8_ALT = 2'b11
    } precision_e;

    typedef enum logic [1:0] {
        MUL    = 2'b00,
        MULH   = 2'b01,
        MULHU  = 2'b10,
        MULHSU = 2'b11
    } opcode_e;

    localparam int LANE_BYTES = 4;
    localparam int PROD_W     = 64;
    localparam int RES_W      = 32;

    // Byte index holding the sign of the lane that covers byte_idx.
    function automatic logic [1:0] lane_top_byte(input precision_e prec, input logic [1:0] byte_idx);
        case (prec)
            P16:     return {byte_idx[1], 1'b1};
            P32:     return 2'd3;
            default: return byte_idx;
        endcase
    endfunction

endpackage

// File: rtl/product_sign_restore_if.sv
// rtl/product_sign_restore_if.sv - product/sign input and result output handshake bundle
interface product_sign_restore_if;
    import vmul_pkg::*;

    logic                   in_valid;
    logic                   in_ready;
    precision_e             precision;
    opcode_e                opcode;
    logic [LANE_BYTES-1:0]  sign_a;
    logic [LANE_BYTES-1:0]  sign_b;
    logic [PROD_W-1:0]      product;
    logic                   out_valid;
    logic                   out_ready;
    logic [RES_W-1:0]       result;
    logic [LANE_BYTES-1:0]  out_neg;

    modport master (
        output in_valid, precision, opcode, sign_a, sign_b, product, out_ready,
        input  in_ready, out_valid, result, out_neg
    );

    modport slave (
        input  in_valid, precision, opcode, sign_a, sign_b, product, out_ready,
        output in_ready, out_valid, result, out_neg
    );

endinterface

// File: rtl/lane_segmented_negate.sv
// rtl/lane_segmented_negate.sv - per-lane two's complement of the raw product, carries confined to each lane
module lane_segmented_negate
    import vmul_pkg::*;
(
    input  logic [PROD_W-1:0]     i_x,
    input  precision_e            i_precision,
    input  logic [LANE_BYTES-1:0] i_neg,
    output logic [PROD_W-1:0]     o_y
);

    // Each lane is negated on its own slice so no carry can leak into the next lane.
    always_comb begin
        o_y = i_x;
        case (i_precision)
            P16: begin
                for (int l = 0; l < 2; l++) begin
                    if (i_neg[2*l+1]) o_y[32*l +: 32] = ~i_x[32*l +: 32] + 32'd1;
                end
            end
            P32: begin
                if (i_neg[3]) o_y = ~i_x + 64'd1;
            end
            default: begin
                for (int l = 0; l < 4; l++) begin
                    if (i_neg[l]) o_y[16*l +: 16] = ~i_x[16*l +: 16] + 16'd1;
                end
            end
        endcase
    end

endmodule

// File: rtl/product_sign_restore.sv
// rtl/product_sign_restore.sv - two-stage pipeline re-applying lane signs to the magnitude product
module product_sign_restore
    import vmul_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    product_sign_restore_if.slave  bus
);

    logic                   r_s1_valid;
    logic [PROD_W-1:0]      r_s1_product;
    precision_e             r_s1_precision;
    opcode_e                r_s1_opcode;
    logic [LANE_BYTES-1:0]  r_s1_neg;

    logic                   r_out_valid;
    logic [RES_W-1:0]       r_result;
    logic [LANE_BYTES-1:0]  r_out_neg;

    logic                   w_s1_en;
    logic                   w_s2_en;
    logic [LANE_BYTES-1:0]  w_byte_neg;
    logic [PROD_W-1:0]      w_negated;
    logic [RES_W-1:0]       w_half;
    logic                   w_high;

    assign w_s2_en      = !r_out_valid || bus.out_ready;
    assign w_s1_en      = !r_s1_valid || w_s2_en;
    assign bus.in_ready = w_s1_en;

    // Every byte takes the sign of its lane's top byte, so the flag is replicated across the lane.
    always_comb begin
        w_byte_neg = '0;
        for (int b = 0; b < LANE_BYTES; b++) begin
            w_byte_neg[b] = bus.sign_a[lane_top_byte(bus.precision, 2'(b))]
                          ^ bus.sign_b[lane_top_byte(bus.precision, 2'(b))];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_valid     <= 1'b0;
            r_s1_product   <= '0;
            r_s1_precision <= P8;
            r_s1_opcode    <= MUL;
            r_s1_neg       <= '0;
        end else if (w_s1_en) begin
            r_s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_s1_product   <= bus.product;
                r_s1_precision <= bus.precision;
                r_s1_opcode    <= bus.opcode;
                r_s1_neg       <= w_byte_neg;
            end
        end
    end

    lane_segmented_negate u_negate (
        .i_x         (r_s1_product),
        .i_precision (r_s1_precision),
        .i_neg       (r_s1_neg),
        .o_y         (w_negated)
    );

    assign w_high = (r_s1_opcode != MUL);

    always_comb begin
        w_half = '0;
        case (r_s1_precision)
            P16: begin
                for (int l = 0; l < 2; l++) begin
                    w_half[16*l +: 16] = w_high ? w_negated[32*l+16 +: 16] : w_negated[32*l +: 16];
                end
            end
            P32: begin
                w_half = w_high ? w_negated[63:32] : w_negated[31:0];
            end
            default: begin
                for (int l = 0; l < 4; l++) begin
                    w_half[8*l +: 8] = w_high ? w_negated[16*l+8 +: 8] : w_negated[16*l +: 8];
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_out_neg   <= '0;
        end else if (w_s2_en) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_result  <= w_half;
                r_out_neg <= r_s1_neg;
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.result    = r_result;
    assign bus.out_neg   = r_out_neg;

endmodule
